// File: rtl/v_pkg.sv
// Shared types for the per-context list state. The query pipe and the update
// pipe both use these.
package v_pkg;
  localparam int CONTEXT_N = 128;
  localparam int ENTRIES_N = 4;
  localparam int ID_W      = 8;
  localparam int ADDR_W    = $clog2(CONTEXT_N);
  localparam int LEVEL_W   = $clog2(ENTRIES_N);
  localparam int LS_W      = $clog2(ENTRIES_N + 1);

  typedef logic [ID_W-1:0]    id_t;
  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [LEVEL_W-1:0] level_t;
  typedef logic [63:0]        key_t;
  typedef logic [31:0]        size_t;
  typedef logic [LS_W-1:0]    listsize_t;

  typedef struct packed {
    key_t  key;
    size_t size;
  } entry_t;

  typedef struct packed {
    listsize_t                listsize;
    entry_t [ENTRIES_N-1:0]   entries;
  } state_t;

  // Corrupt occupancy values above ENTRIES_N are clamped to a full list.
  function automatic listsize_t sat_listsize(input listsize_t ls);
    return (ls > listsize_t'(ENTRIES_N)) ? listsize_t'(ENTRIES_N) : ls;
  endfunction
endpackage

// File: rtl/v_state_fwd.sv
// Write-snoop forwarding for a 1-cycle-latency SRAM: one registered write from
// the read cycle, plus the live write in the data cycle. The live write wins.
module v_state_fwd
  import v_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  addr_t  i_raddr,
  input  logic   i_wen,
  input  addr_t  i_waddr,
  input  state_t i_wdata,
  input  addr_t  i_s1_addr,
  input  state_t i_rdata,
  output state_t o_state
);
  logic   r_fwd0_vld;
  state_t r_fwd0_data;
  logic   w_hit0;
  logic   w_hit1;

  assign w_hit0 = i_wen && (i_waddr == i_raddr);
  assign w_hit1 = i_wen && (i_waddr == i_s1_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fwd0_vld  <= 1'b0;
      r_fwd0_data <= '0;
    end else begin
      r_fwd0_vld <= w_hit0;
      if (w_hit0) r_fwd0_data <= i_wdata;
    end
  end

  always_comb begin
    o_state = i_rdata;
    if (w_hit1)          o_state = i_wdata;
    else if (r_fwd0_vld) o_state = r_fwd0_data;
  end
endmodule

// File: rtl/v_lut_pipe.sv
// Read-side lookup of per-context list state: one query per cycle, response
// two cycles later, with in-flight update writes forwarded.
module v_lut_pipe
  import v_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      i_lut_vld,
  input  id_t       i_lut_prod_id,
  input  level_t    i_lut_level,
  output logic      o_state_ren,
  output addr_t     o_state_raddr,
  input  state_t    i_state_rdata,
  input  logic      i_state_wen,
  input  addr_t     i_state_waddr,
  input  state_t    i_state_wdata,
  output logic      o_lut_vld,
  output key_t      o_lut_key,
  output size_t     o_lut_size,
  output logic      o_lut_error,
  output listsize_t o_lut_listsize
);
  logic      r_rst_q;
  logic      w_accept;
  logic      w_id_ok;
  logic      r_s1_vld;
  logic      r_s1_id_ok;
  level_t    r_s1_level;
  addr_t     r_s1_addr;
  state_t    w_state;
  listsize_t w_ls;
  logic      w_err;
  entry_t    w_entry;

  // Queries arriving in the first cycle after reset are dropped.
  assign w_accept      = i_lut_vld & ~r_rst_q;
  assign w_id_ok       = i_lut_prod_id < id_t'(CONTEXT_N);
  assign o_state_ren   = w_accept & w_id_ok;
  assign o_state_raddr = i_lut_prod_id[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    r_rst_q <= rst;
    if (rst) begin
      r_s1_vld   <= 1'b0;
      r_s1_id_ok <= 1'b0;
      r_s1_level <= '0;
      r_s1_addr  <= '0;
    end else begin
      r_s1_vld   <= w_accept;
      r_s1_id_ok <= w_id_ok;
      r_s1_level <= i_lut_level;
      r_s1_addr  <= o_state_raddr;
    end
  end

  v_state_fwd u_fwd (
    .clk       (clk),
    .rst       (rst),
    .i_raddr   (o_state_raddr),
    .i_wen     (i_state_wen),
    .i_waddr   (i_state_waddr),
    .i_wdata   (i_state_wdata),
    .i_s1_addr (r_s1_addr),
    .i_rdata   (i_state_rdata),
    .o_state   (w_state)
  );

  always_comb begin
    w_ls    = sat_listsize(w_state.listsize);
    w_err   = ~r_s1_id_ok | (listsize_t'(r_s1_level) >= w_ls);
    w_entry = w_err ? '0 : w_state.entries[r_s1_level];
  end

  always_ff @(posedge clk) begin
    if (rst || !r_s1_vld) begin
      o_lut_vld      <= 1'b0;
      o_lut_key      <= '0;
      o_lut_size     <= '0;
      o_lut_error    <= 1'b0;
      o_lut_listsize <= '0;
    end else begin
      o_lut_vld      <= 1'b1;
      o_lut_key      <= w_entry.key;
      o_lut_size     <= w_entry.size;
      o_lut_error    <= w_err;
      o_lut_listsize <= r_s1_id_ok ? w_ls : '0;
    end
  end
endmodule

// File: doc/v_lut_pipe.md
Name: v_lut_pipe

Overview:
- Read-side lookup pipeline for the per-context list state. The update pipe writes this state into the query-side SRAM copy; this block reads it back.
- Accepts one List Query Bus request per cycle and issues a read to the query SRAM (1-cycle read latency).
- Forwards in-flight update-pipe writes to the same context, so every response reflects all writes issued up to and including the request's read cycle.
- Returns key, size, error and list size for the requested level with a fixed 2-cycle latency.

Parameters:
- CONTEXT_N, 128: number of contexts; SRAM depth.
- ENTRIES_N, 4: entries per context list; level range is 0..ENTRIES_N-1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_lut_vld  in  1  query valid
- i_lut_prod_id  in  v_pkg::id_t (8)  context id
- i_lut_level  in  v_pkg::level_t (2)  list position to read
- o_state_ren  out  1  SRAM read enable
- o_state_raddr  out  v_pkg::addr_t (7)  SRAM read address
- i_state_rdata  in  v_pkg::state_t  SRAM read data, valid 1 cycle after ren
- i_state_wen  in  1  snoop of update-pipe SRAM write enable
- i_state_waddr  in  v_pkg::addr_t (7)  snoop write address
- i_state_wdata  in  v_pkg::state_t  snoop write data
- o_lut_vld  out  1  response valid
- o_lut_key  out  v_pkg::key_t (64)  entry key
- o_lut_size  out  v_pkg::size_t (32)  entry size
- o_lut_error  out  1  lookup error
- o_lut_listsize  out  v_pkg::listsize_t (3)  current list occupancy (0..ENTRIES_N)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: while rst is asserted, at the following edge every o_lut_* output is 0 and all pipeline valids clear.
  - o_state_ren is combinational. It is gated by a registered reset flag and is 0 in the cycle after rst.
- No backpressure. A query may be presented every cycle, and responses return in order.
- Stage 0, cycle T:
  - o_state_ren = i_lut_vld & id_ok, where id_ok = (i_lut_prod_id < CONTEXT_N).
  - o_state_raddr = i_lut_prod_id[6:0].
  - Register vld, id_ok, level and addr into stage 1.
  - Also register the write snoop when i_state_wen & (i_state_waddr == raddr); call it fwd0.
- SRAM read-during-write to the same address returns OLD data. The forwarding below covers this case.
- Stage 1, cycle T+1: select the state for the response, first match wins:
  - (a) i_state_wen and i_state_waddr == s1_addr: use i_state_wdata (youngest write).
  - (b) else fwd0 valid: use the fwd0 data.
  - (c) else: use i_state_rdata.
- Response fields (both error cases are mutually consistent):
  - error = !id_ok | (level >= state.listsize).
  - listsize = id_ok ? state.listsize : 0.
  - key and size = state.entries[level] when not error, else 0.
- Output, cycle T+2: o_lut_vld = 1, with all fields registered. When o_lut_vld = 0, the o_lut_* data outputs hold 0 (not the previous response).
- Latency: exactly 2 cycles from i_lut_vld to o_lut_vld.
- Boundary conditions:
  - listsize == 0: every level returns error.
  - level == ENTRIES_N-1 with listsize == ENTRIES_N: valid.
  - A listsize greater than ENTRIES_N in SRAM is treated as ENTRIES_N (saturate) before comparison.
  - Back-to-back queries to the same id, with interleaved writes, each see the latest write at or before their own stage-1 cycle.
  - rst asserted mid-operation: in-flight queries are discarded, and no o_lut_vld is produced for queries accepted before or during rst.
  - A query with i_lut_vld in the same cycle as rst is ignored.

Decomposition:
- v_pkg holds the shared types and constants:
  - id_t, addr_t = $clog2(CONTEXT_N), level_t = $clog2(ENTRIES_N), key_t, size_t, listsize_t = $clog2(ENTRIES_N+1).
  - entry_t = {key_t key; size_t size}.
  - state_t = {listsize_t listsize; entry_t entries[ENTRIES_N]}.
  - These are shared with the update pipe.
- One sub-module, v_state_fwd: a 2-deep write-snoop and priority-select unit (stage-0 capture plus the stage-1 mux). It is reusable by the update pipe for its own read-modify-write hazard.

Test Plan:
- Directed scenarios, using a behavioural SRAM model (1-cycle read latency, read-during-write returns old data).
- Preload ctx 5: listsize=2, entries {0x11,8},{0x22,16}. Query (5, level 1) at T. Expect at T+2: vld=1, key=0x22, size=16, error=0, listsize=2.
- Same ctx 5, query level 2. Expect error=1, key=0, size=0, listsize=2.
- Query prod_id=200 (>=CONTEXT_N). Expect o_state_ren=0 at T and error=1, listsize=0 at T+2.
- Forwarding on ctx 5:
  - Write listsize=3, entry[2]={0x33,4} at cycle T, with the query (5, level 2) also at T. Expect key=0x33, error=0 (fwd0 path).
  - Repeat with the write at T+1. Expect the same result (youngest-write path).
  - A write at T+1 to ctx 6 must not affect the response.
- Back-to-back queries to ctx 5 levels 0,1,2,3 on consecutive cycles. Expect 4 consecutive vld pulses, in order, each 2 cycles after its query.
- Queries at T and T+1, rst asserted at T+1 for 1 cycle. Expect no o_lut_vld at T+2 or T+3, and all o_lut_* outputs = 0. A fresh query after reset succeeds with 2-cycle latency.
